// File: rtl/io_output_stream_ram.sv
// io_output_stream_ram
//
// Purpose:
//   This module is the IO output RAM written by the processor datapath, with
//   change streaming added.
//   - Each store-to-IO write lands in a DEPTH-entry register file and marks
//     that entry dirty.
//   - A round-robin scanner walks the dirty bits. It presents each changed
//     entry as an index/data pair on a valid/ready stream to the display or
//     host side.
//   - A registered readback port returns entry[address] one cycle later.
//
// Ports:
//   clock          - sole clock, rising edge
//   reset          - synchronous, active-low reset
//   IO_RAMwrite    - write enable from the control unit
//   address        - write and readback address (ADDR_WIDTH)
//   dataC          - write data (DATA_WIDTH)
//   IO_RAMOutput   - registered readback of entry[address], 0 when out of range
//   stream_valid   - stream word available
//   stream_ready   - consumer accepts the stream word
//   stream_index   - index of the streamed entry (IDX_WIDTH)
//   stream_data    - snapshot of the streamed entry (DATA_WIDTH)
//   pending_count  - number of dirty entries (CNT_WIDTH)
//   range_error    - sticky flag for writes with address >= DEPTH
//
// Optional feature:
//   IO_OUT_RANGE_CHECK_EN - when defined, range_error latches on any write
//   with address >= DEPTH. When undefined, range_error is tied to 0.
//   Out-of-range writes are always ignored by the storage.

module io_output_stream_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 32,
  parameter int IDX_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IO_RAMwrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataC,
  output logic [DATA_WIDTH-1:0] IO_RAMOutput,
  output logic                  stream_valid,
  input  logic                  stream_ready,
  output logic [IDX_WIDTH-1:0]  stream_index,
  output logic [DATA_WIDTH-1:0] stream_data,
  output logic [CNT_WIDTH-1:0]  pending_count,
  output logic                  range_error
);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  localparam logic [ADDR_WIDTH:0]  DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      dirty_q, dirty_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  stream_valid_q, stream_valid_d;
  logic [IDX_WIDTH-1:0]  stream_index_q, stream_index_d;
  logic [DATA_WIDTH-1:0] stream_data_q, stream_data_d;

  logic                  in_range;
  logic                  wr_en;
  logic                  load;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  ptr_inc;

  // Address decode. The index slice is only meaningful when in_range is set.
  // The pointer increment wraps explicitly, so non-power-of-two depths work.
  always_comb begin
    in_range = ({1'b0, address} < DEPTH_A);
    wr_idx   = address[IDX_WIDTH-1:0];
    wr_en    = IO_RAMwrite && in_range;
    ptr_inc  = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_WIDTH'(1);
  end

  // The scan/present FSM, storage update and pending counter.
  // - A load clears the dirty bit first. A write then sets its dirty bit, so
  //   a write to the entry being loaded keeps it dirty for a later pass.
  // - The counter only moves on clean->dirty and dirty->clean transitions.
  //   This keeps it equal to the popcount of dirty_q.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    mem_d          = mem_q;
    dirty_d        = dirty_q;
    stream_valid_d = stream_valid_q;
    stream_index_d = stream_index_q;
    stream_data_d  = stream_data_q;
    load           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|dirty_q) state_d = SCAN;
      end
      SCAN: begin
        if (dirty_q[ptr_q]) begin
          load           = 1'b1;
          stream_data_d  = mem_q[ptr_q];
          stream_index_d = ptr_q;
          stream_valid_d = 1'b1;
          state_d        = PRESENT;
        end else begin
          ptr_d = ptr_inc;
          if (dirty_q == '0) state_d = IDLE;
        end
      end
      PRESENT: begin
        if (stream_ready) begin
          stream_valid_d = 1'b0;
          ptr_d          = ptr_inc;
          state_d        = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) dirty_d[ptr_q] = 1'b0;
    if (wr_en) begin
      mem_d[wr_idx]   = dataC;
      dirty_d[wr_idx] = 1'b1;
    end

    count_d = count_q
            + CNT_WIDTH'(wr_en && !dirty_q[wr_idx])
            - CNT_WIDTH'(load && !(wr_en && (wr_idx == ptr_q)));

    rd_data_d = in_range ? mem_q[wr_idx] : '0;
  end

  // State registers. Reset wins over any write or handshake in the same
  // cycle, so a word that is mid-handshake is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      mem_q          <= '{default: '0};
      dirty_q        <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      stream_valid_q <= 1'b0;
      stream_index_q <= '0;
      stream_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      mem_q          <= mem_d;
      dirty_q        <= dirty_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      stream_valid_q <= stream_valid_d;
      stream_index_q <= stream_index_d;
      stream_data_q  <= stream_data_d;
    end
  end

`ifdef IO_OUT_RANGE_CHECK_EN
  logic range_error_q, range_error_d;

  // Sticky flag for writes that miss the array. Only reset clears it.
  always_comb begin
    range_error_d = range_error_q | (IO_RAMwrite && !in_range);
  end

  always_ff @(posedge clock) begin
    if (!reset) range_error_q <= 1'b0;
    else        range_error_q <= range_error_d;
  end

  assign range_error = range_error_q;
`else
  assign range_error = 1'b0;
`endif

  assign IO_RAMOutput  = rd_data_q;
  assign stream_valid  = stream_valid_q;
  assign stream_index  = stream_index_q;
  assign stream_data   = stream_data_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_io_output_stream_ram.sv
// Testbench for io_output_stream_ram using directed vectors with hand-computed
// expectations. It uses the default parameters: DEPTH=32, DATA_WIDTH=32 and
// ADDR_WIDTH=10. Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at that same point, so each check sees the result of
// the edge just taken.

module tb_io_output_stream_ram;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 32;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          IO_RAMwrite;
  logic [AW-1:0] address;
  logic [DW-1:0] dataC;
  logic [DW-1:0] IO_RAMOutput;
  logic          stream_valid;
  logic          stream_ready;
  logic [IW-1:0] stream_index;
  logic [DW-1:0] stream_data;
  logic [CW-1:0] pending_count;
  logic          range_error;

  int assertions = 0;
  int failures   = 0;

  io_output_stream_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .IO_RAMwrite(IO_RAMwrite),
    .address(address), .dataC(dataC), .IO_RAMOutput(IO_RAMOutput),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_index(stream_index), .stream_data(stream_data),
    .pending_count(pending_count), .range_error(range_error)
  );

  always #5 clock = ~clock;

  // Every comparison goes through this task.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input int addr, input logic [DW-1:0] data,
                               input logic rdy);
    IO_RAMwrite  = we;
    address      = AW'(addr);
    dataC        = data;
    stream_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    applyStimulus(1'b0, 0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    checkOutput("rst_valid", stream_valid, 0);
    checkOutput("rst_count", pending_count, 0);
  endtask

  // Waits up to budget edges for stream_valid, then checks the presented word.
  task automatic waitWord(input string tag, input int budget, input int exp_idx,
                          input logic [DW-1:0] exp_data);
    int n;
    n = 0;
    while (!stream_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, stream_valid, 1);
    checkOutput({tag, "_index"}, stream_index, exp_idx);
    checkOutput({tag, "_data"},  stream_data,  exp_data);
  endtask

  // Completes the handshake on a presented word.
  task automatic acceptWord(input string tag);
    stream_ready = 1'b1;
    tick();
    stream_ready = 1'b0;
    checkOutput({tag, "_drop"}, stream_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset is held while a write is attempted, and the write must not land.
    reset = 1'b0;
    applyStimulus(1'b1, 3, 32'hAA, 1'b0);
    tick();
    tick();
    checkOutput("reset_rd",    IO_RAMOutput, 0);
    checkOutput("reset_valid", stream_valid, 0);
    checkOutput("reset_count", pending_count, 0);
    checkOutput("reset_idx",   stream_index, 0);
    checkOutput("reset_data",  stream_data, 0);
    checkOutput("reset_rerr",  range_error, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 3, '0, 1'b0);
    tick();
    checkOutput("reset_entry3", IO_RAMOutput, 0);
    checkOutput("reset_count2", pending_count, 0);

    // Readback is read-before-write, with one cycle of latency.
    applyStimulus(1'b1, 5, 32'h1234, 1'b0);
    tick();
    checkOutput("rb_write_cycle", IO_RAMOutput, 0);
    checkOutput("rb_count", pending_count, 1);
    applyStimulus(1'b0, 5, '0, 1'b0);
    tick();
    checkOutput("rb_next_cycle", IO_RAMOutput, 32'h1234);
    waitWord("rb_stream", DEPTH + 4, 5, 32'h1234);
    checkOutput("rb_count_load", pending_count, 0);
    acceptWord("rb");

    // Backpressure holds the presented word stable.
    resetDut();
    applyStimulus(1'b1, 2, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 7, 32'h22, 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("bp_count2", pending_count, 2);
    waitWord("bp_first", DEPTH + 4, 2, 32'h11);
    checkOutput("bp_count1", pending_count, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_valid", stream_valid, 1);
      checkOutput("bp_hold_idx",   stream_index, 2);
      checkOutput("bp_hold_data",  stream_data, 32'h11);
    end
    acceptWord("bp_first");
    waitWord("bp_second", DEPTH + 4, 7, 32'h22);
    checkOutput("bp_count0", pending_count, 0);
    acceptWord("bp_second");

    // A second write coalesces into the dirty entry, and the snapshot holds.
    resetDut();
    applyStimulus(1'b1, 4, 32'h01, 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    waitWord("co_first", DEPTH + 4, 4, 32'h01);
    applyStimulus(1'b1, 4, 32'h02, 1'b0);
    tick();
    applyStimulus(1'b0, 4, '0, 1'b0);
    checkOutput("co_count", pending_count, 1);
    tick();
    checkOutput("co_snap_data", stream_data, 32'h01);
    checkOutput("co_snap_valid", stream_valid, 1);
    checkOutput("co_rd_new", IO_RAMOutput, 32'h02);
    acceptWord("co_first");
    waitWord("co_second", DEPTH + 4, 4, 32'h02);
    checkOutput("co_count0", pending_count, 0);
    acceptWord("co_second");

    // Wrap-around: entry 31 is presented, so the pointer sits at DEPTH-1.
    // The scan must then wrap to index 0.
    resetDut();
    applyStimulus(1'b1, 31, 32'h31, 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    waitWord("wrap_last", DEPTH + 2, 31, 32'h31);
    applyStimulus(1'b1, 0, 32'h5A, 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    acceptWord("wrap_last");
    waitWord("wrap_zero", DEPTH + 1, 0, 32'h5A);
    acceptWord("wrap_zero");

    // An out-of-range write must not alias into entry 8 (40 mod 32).
    resetDut();
    applyStimulus(1'b1, 40, 32'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 40, '0, 1'b0);
`ifdef IO_OUT_RANGE_CHECK_EN
    checkOutput("range_err_set", range_error, 1);
`else
    checkOutput("range_err_off", range_error, 0);
`endif
    checkOutput("range_count", pending_count, 0);
    checkOutput("range_rd", IO_RAMOutput, 0);
    applyStimulus(1'b0, 8, '0, 1'b0);
    for (int i = 0; i < DEPTH + 4; i++) tick();
    checkOutput("range_no_stream", stream_valid, 0);
    checkOutput("range_entry8", IO_RAMOutput, 0);
`ifdef IO_OUT_RANGE_CHECK_EN
    checkOutput("range_err_sticky", range_error, 1);
`else
    checkOutput("range_err_off2", range_error, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/io_output_stream_ram.md
Name: io_output_stream_ram

Overview:
- Parametrised successor to the processor's IO output RAM.
- Stores words written by the datapath (store-to-IO path) into a DEPTH-entry register file.
- Provides a registered readback port.
- Tracks per-entry dirty bits and streams each changed entry, as an index/data pair, over a valid/ready handshake to the display or host side.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 10, width of the datapath address bus.
- DEPTH, 32, number of entries; legal range 2 to 2^ADDR_WIDTH.
- IDX_WIDTH, $clog2(DEPTH), width of the stream index.
- CNT_WIDTH, $clog2(DEPTH+1), width of the pending counter.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- IO_RAMwrite  in  1  write enable from the control unit.
- address  in  ADDR_WIDTH  write and readback address.
- dataC  in  DATA_WIDTH  write data.
- IO_RAMOutput  out  DATA_WIDTH  registered readback of entry[address].
- stream_valid  out  1  stream word available.
- stream_ready  in  1  consumer accepts the stream word.
- stream_index  out  IDX_WIDTH  index of the streamed entry.
- stream_data  out  DATA_WIDTH  snapshot of the streamed entry.
- pending_count  out  CNT_WIDTH  number of dirty entries.
- range_error  out  1  sticky out-of-range-write flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at the clock edge):
  - All entries are cleared to 0; all dirty bits are cleared to 0.
  - IO_RAMOutput=0, stream_valid=0, stream_index=0, stream_data=0, pending_count=0, range_error=0.
  - Scan pointer=0; FSM goes to IDLE.
  - Reset overrides any concurrent write or handshake. A stream word that is mid-handshake is dropped, not replayed.
- Write: when IO_RAMwrite=1 and address<DEPTH, then entry[address]<=dataC and dirty[address]<=1.
  - A write to an already-dirty entry overwrites the data; the dirty bit stays 1 and the entry is streamed once.
- Readback: IO_RAMOutput <= entry[address] every cycle, one-cycle latency.
  - Read-before-write: a same-cycle write to the same address returns the old value; the new value appears the next cycle.
  - For address>=DEPTH, IO_RAMOutput <= 0.
- pending_count equals the popcount of the dirty bits, registered so it matches the dirty bits after the edge.
  - It increments only when a clean entry is written.
  - It decrements when an entry is loaded for streaming.
  - A simultaneous set and clear on different entries leaves the count unchanged.
- FSM:
  - IDLE: stream_valid=0. If any dirty bit is set, go to SCAN; the pointer is kept, not reset.
  - SCAN, one entry per cycle:
    - If dirty[ptr]=1: stream_data<=entry[ptr], stream_index<=ptr, dirty[ptr]<=0, stream_valid<=1; go to PRESENT.
    - Else: ptr<=ptr+1, wrapping DEPTH-1 to 0. If no dirty bits remain, go to IDLE.
  - PRESENT: stream_valid=1; stream_index and stream_data are held stable until stream_ready=1.
    - On stream_valid&&stream_ready: stream_valid<=0, ptr<=ptr+1 (with wrap), go to SCAN.
    - Round-robin order guarantees no starvation.
- Load coincident with a write to the same entry: the write wins for the dirty bit (dirty stays 1, count unchanged). The snapshot holds the old data; the new data is streamed on a later pass.
- A write during PRESENT to the presented entry does not change stream_data; it sets dirty for a later pass.
- stream_ready while stream_valid=0 is ignored.
- Worst-case latency from a write to stream_valid, with the stream idle: DEPTH+1 cycles.

Optional Feature:
- Macro: IO_OUT_RANGE_CHECK_EN.
- Defined:
  - A write with address>=DEPTH sets range_error<=1, which stays set until reset.
  - The entry array, dirty bits and count are unaffected.
- Undefined:
  - range_error is tied to 0 and its logic is not compiled in.
  - Out-of-range writes are still silently ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles with IO_RAMwrite=1, address=3, dataC=0xAA. Then: IO_RAMOutput=0, stream_valid=0, pending_count=0, and entry 3 reads back 0 after reset is released.
- Readback: write 0x1234 to address 5, then hold address=5 with IO_RAMwrite=0. IO_RAMOutput=0x1234 one cycle after the write edge. In the write cycle itself it still shows 0.
- Stream with backpressure: write 0x11 to address 2 and 0x22 to address 7, with stream_ready=0. stream_valid=1 with index 2, data 0x11, held stable for 5 cycles. Then raise stream_ready: the next word is index 7, data 0x22. pending_count steps 2, 1, 0.
- Coalescing and snapshot: write 0x01 to address 4, let it load (PRESENT), then write 0x02 to address 4 with stream_ready=0. stream_data stays 0x01. After the handshake, index 4 is streamed again with 0x02.
- Wrap-around: with the pointer at DEPTH-1 (entry 31), write to address 0. The scan wraps and streams index 0 within DEPTH+1 cycles.
- With IO_OUT_RANGE_CHECK_EN defined, write to address 40 (DEPTH=32). range_error=1 on the next cycle and stays set. pending_count=0 and no stream word is produced.
